// File: rtl/delta_pkg.sv
// Shared definitions for the delta trace compressor/decompressor pair: slot layout,
// empty-slot marker and the FSM state type.
package delta_pkg;

  localparam int unsigned MaxWidth      = 64;
  localparam int unsigned DefDataWidth  = 32;
  localparam int unsigned DefDeltaSlots = 4;

  // Constants for the default geometry; other geometries go through the functions below.
  localparam int unsigned                PRECISION = DefDataWidth / DefDeltaSlots;
  localparam logic [PRECISION-1:0]       INV       = {1'b1, {(PRECISION - 1) {1'b0}}};
  localparam logic [DefDataWidth-1:0]    NODATA    = {DefDeltaSlots{INV}};

  typedef logic [MaxWidth-1:0] word_t;

  typedef enum logic [1:0] {
    StNoAnchor,
    StAnchored,
    StUnpack
  } state_e;

  // Low prec bits set; prec == MaxWidth yields all ones.
  function automatic word_t field_mask(input int unsigned prec);
    return (word_t'(1) << prec) - word_t'(1);
  endfunction

  // Slot 0 sits in the MSBs and holds the oldest delta.
  function automatic word_t slot_extract(input word_t       lane_word,
                                         input int unsigned slot,
                                         input int unsigned prec,
                                         input int unsigned slots);
    return (lane_word >> ((slots - slot - 1) * prec)) & field_mask(prec);
  endfunction

  function automatic word_t sext_field(input word_t field, input int unsigned prec);
    word_t sign;
    sign = field >> (prec - 1);
    if (sign[0]) begin
      return field | ~field_mask(prec);
    end else begin
      return field & field_mask(prec);
    end
  endfunction

  // Empty-slot marker: the most negative delta value.
  function automatic word_t inv_field(input int unsigned prec);
    return word_t'(1) << (prec - 1);
  endfunction

endpackage

// File: rtl/delta_slot_unpack.sv
// Combinational slot datapath: per-lane slot select, sign extension and anchor add, plus
// the highest-used-slot encoder for a newly arriving compressed entry.
module delta_slot_unpack
  import delta_pkg::*;
#(
  parameter int unsigned Lanes      = 8,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned DeltaSlots = 4,
  parameter int unsigned SlotW      = (DeltaSlots > 1) ? $clog2(DeltaSlots) : 1
) (
  input  logic [Lanes*DataWidth-1:0] entry_i,
  input  logic [Lanes*DataWidth-1:0] anchor_i,
  input  logic [SlotW-1:0]           slot_i,
  input  logic [DataWidth-1:0]       enc_lane_i,
  output logic [Lanes*DataWidth-1:0] sum_o,
  output logic [SlotW-1:0]           hi_slot_o,
  output logic                       any_used_o
);

  localparam int unsigned Prec = DataWidth / DeltaSlots;

  // Add the sign-extended delta of the selected slot to every lane of the anchor.
  always_comb begin
    word_t field;
    word_t delta;
    sum_o = '0;
    field = '0;
    delta = '0;
    for (int unsigned i = 0; i < Lanes; i++) begin
      field = slot_extract(word_t'(entry_i[i*DataWidth +: DataWidth]), int'(slot_i), Prec,
                           DeltaSlots);
      delta = sext_field(field, Prec);
      sum_o[i*DataWidth +: DataWidth] = anchor_i[i*DataWidth +: DataWidth] +
                                        delta[DataWidth-1:0];
    end
  end

  // Highest slot whose lane-0 field is not the empty marker; later slots win.
  always_comb begin
    hi_slot_o  = '0;
    any_used_o = 1'b0;
    for (int unsigned k = 0; k < DeltaSlots; k++) begin
      if (slot_extract(word_t'(enc_lane_i), k, Prec, DeltaSlots) != inv_field(Prec)) begin
        hi_slot_o  = SlotW'(k);
        any_used_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/delta_decompressor.sv
// Readback decoder for the delta-compressed trace buffer. Entries arrive newest-first;
// raw entries set the anchor, compressed entries are unpacked one slot per cycle, newest
// slot first, producing the original vectors in reverse chronological order.
module delta_decompressor
  import delta_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned DELTA_SLOTS = DefDeltaSlots,
  parameter bit          COMPRESSED  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_vector,
  input  logic                    in_comp,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*DATA_WIDTH-1:0] out_vector,
  output logic [15:0]             dropped_count
);

  localparam int unsigned VecW  = N * DATA_WIDTH;
  localparam int unsigned SlotW = (DELTA_SLOTS > 1) ? $clog2(DELTA_SLOTS) : 1;

  state_e            state_q, state_d;
  logic [VecW-1:0]   anchor_q, anchor_d;
  logic [VecW-1:0]   entry_q, entry_d;
  logic [SlotW-1:0]  slot_q, slot_d;
  logic              out_valid_q, out_valid_d;
  logic [VecW-1:0]   out_vector_q, out_vector_d;
  logic [15:0]       dropped_q, dropped_d;

  logic [VecW-1:0]   sum;
  logic [SlotW-1:0]  hi_slot;
  logic              any_used;
  logic              out_free;
  logic              is_comp;

  delta_slot_unpack #(
    .Lanes      (N),
    .DataWidth  (DATA_WIDTH),
    .DeltaSlots (DELTA_SLOTS),
    .SlotW      (SlotW)
  ) u_unpack (
    .entry_i    (entry_q),
    .anchor_i   (anchor_q),
    .slot_i     (slot_q),
    .enc_lane_i (in_vector[DATA_WIDTH-1:0]),
    .sum_o      (sum),
    .hi_slot_o  (hi_slot),
    .any_used_o (any_used)
  );

  assign out_free = !out_valid_q || out_ready;
  assign is_comp  = (in_comp == COMPRESSED);

  // Next-state: start overrides everything, then per-state entry handling and unpacking.
  always_comb begin
    state_d      = state_q;
    anchor_d     = anchor_q;
    entry_d      = entry_q;
    slot_d       = slot_q;
    out_valid_d  = out_valid_q;
    out_vector_d = out_vector_q;
    dropped_d    = dropped_q;
    in_ready     = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (start) begin
      state_d     = StNoAnchor;
      out_valid_d = 1'b0;
      dropped_d   = '0;
    end else begin
      unique case (state_q)
        StNoAnchor: begin
          // out_valid is always low here, so the output register is free.
          in_ready = rst_n;
          if (in_valid && rst_n) begin
            if (!is_comp) begin
              anchor_d     = in_vector;
              out_vector_d = in_vector;
              out_valid_d  = 1'b1;
              state_d      = StAnchored;
            end else if (dropped_q != 16'hFFFF) begin
              dropped_d = dropped_q + 16'd1;
            end
          end
        end
        StAnchored: begin
          in_ready = out_free && rst_n;
          if (in_valid && in_ready) begin
            if (!is_comp) begin
              anchor_d     = in_vector;
              out_vector_d = in_vector;
              out_valid_d  = 1'b1;
            end else if (any_used) begin
              entry_d = in_vector;
              slot_d  = hi_slot;
              state_d = StUnpack;
            end
            // A compressed entry with no used slot is swallowed silently.
          end
        end
        StUnpack: begin
          if (out_free) begin
            anchor_d     = sum;
            out_vector_d = sum;
            out_valid_d  = 1'b1;
            if (slot_q == '0) begin
              state_d = StAnchored;
            end else begin
              slot_d = slot_q - SlotW'(1);
            end
          end
        end
        default: state_d = StNoAnchor;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StNoAnchor;
      anchor_q     <= '0;
      entry_q      <= '0;
      slot_q       <= '0;
      out_valid_q  <= 1'b0;
      out_vector_q <= '0;
      dropped_q    <= '0;
    end else begin
      state_q      <= state_d;
      anchor_q     <= anchor_d;
      entry_q      <= entry_d;
      slot_q       <= slot_d;
      out_valid_q  <= out_valid_d;
      out_vector_q <= out_vector_d;
      dropped_q    <= dropped_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_vector    = out_vector_q;
  assign dropped_count = dropped_q;

endmodule

// File: tb/tb_delta_decompressor.sv
// Bench for delta_decompressor (N=2, 32-bit lanes, 4 slots, compressed when in_comp=0).
// A reference model turns every accepted entry into the vectors it must produce; a negedge
// process checks each consumed output and dropped_count against it. Directed literals pin
// latency, stalls, reset behaviour and the model itself.
module tb_delta_decompressor;

  localparam int unsigned N  = 2;
  localparam int unsigned DW = 32;
  localparam logic RAW = 1'b1;
  localparam logic CMP = 1'b0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_vector = '0;
  logic          in_comp = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [63:0]   out_vector;
  logic [15:0]   dropped_count;

  int            n_vec = 0;
  int            n_miss = 0;

  logic [63:0]   exp_q[$];
  logic [63:0]   seen[$];
  logic [63:0]   m_anchor = '0;
  bit            m_has = 1'b0;
  logic [15:0]   m_dropped = '0;

  delta_decompressor #(
    .N           (N),
    .DATA_WIDTH  (DW),
    .DELTA_SLOTS (4),
    .COMPRESSED  (1'b0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_vector     (in_vector),
    .in_comp       (in_comp),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_vector    (out_vector),
    .dropped_count (dropped_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Reference: what an accepted entry must produce, from the delta rules directly.
  function automatic void model_accept(input logic [63:0] v, input logic c);
    int          hi;
    logic [7:0]  f;
    logic [31:0] lane;
    if (c == RAW) begin
      m_anchor = v;
      m_has    = 1'b1;
      exp_q.push_back(v);
      return;
    end
    if (!m_has) begin
      if (m_dropped != 16'hFFFF) m_dropped = m_dropped + 16'd1;
      return;
    end
    hi = -1;
    for (int k = 0; k < 4; k++) begin
      f = v[31 - 8*k -: 8];
      if (f != 8'h80) hi = k;
    end
    for (int k = hi; k >= 0; k--) begin
      for (int l = 0; l < 2; l++) begin
        f    = v[32*l + 31 - 8*k -: 8];
        lane = m_anchor[32*l +: 32] + {{24{f[7]}}, f};
        m_anchor[32*l +: 32] = lane;
      end
      exp_q.push_back(m_anchor);
    end
  endfunction

  // Compare process: outputs and counter against the model, then feed this cycle's inputs.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst_n) begin
      check("reset out_valid/in_ready", {out_valid, in_ready}, 2'b00);
      exp_q.delete();
      m_has     = 1'b0;
      m_dropped = '0;
    end else begin
      check("dropped_count", dropped_count, m_dropped);
      if (out_valid && out_ready) begin
        seen.push_back(out_vector);
        if (exp_q.size() == 0) begin
          check("spurious output", out_vector, 64'hx);
        end else begin
          e = exp_q.pop_front();
          check("out_vector", out_vector, e);
        end
      end
      if (start) begin
        exp_q.delete();
        m_has     = 1'b0;
        m_dropped = '0;
      end else if (in_valid && in_ready) begin
        model_accept(in_vector, in_comp);
      end
    end
  end

  // All stimulus tasks start and end just after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [63:0] v, input logic c);
    bit done;
    done      = 1'b0;
    in_valid  = 1'b1;
    in_vector = v;
    in_comp   = c;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) check("accept timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    check("in_ready during start", in_ready, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("out_valid after start", out_valid, 1'b0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    idle(2);
    check("reset out_vector", out_vector, 64'd0);
    check("reset dropped", dropped_count, 16'd0);
    check("reset in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    idle(1);
    pulse_start();

    // Raw entry appears one cycle after acceptance, for one cycle.
    put({32'd200, 32'd100}, RAW);
    check("raw latency valid", out_valid, 1'b1);
    check("raw latency data", out_vector, {32'd200, 32'd100});
    idle(1);
    check("raw single cycle", out_valid, 1'b0);

    // Full compressed entry: four outputs back to back, input blocked meanwhile.
    seen.delete();
    put({32'h0, 32'h0102FF03}, CMP);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) check("in_ready low in unpack", in_ready, 1'b0);
      if (i >= 1) check("out_valid consecutive", out_valid, 1'b1);
    end
    idle(2);
    check("full unpack count", 64'(seen.size()), 64'd4);
    if (seen.size() == 4) begin
      check("full unpack 0", seen[0], {32'd200, 32'd103});
      check("full unpack 1", seen[1], {32'd200, 32'd102});
      check("full unpack 2", seen[2], {32'd200, 32'd104});
      check("full unpack 3", seen[3], {32'd200, 32'd105});
    end

    // Partial entry, then an all-empty entry that yields nothing.
    seen.delete();
    put({32'd10, 32'd10}, RAW);
    put({32'hFF808080, 32'h05808080}, CMP);
    idle(3);
    check("partial count", 64'(seen.size()), 64'd2);
    if (seen.size() == 2) check("partial value", seen[1], {32'd9, 32'd15});
    seen.delete();
    put({32'h80808080, 32'h80808080}, CMP);
    idle(3);
    check("nodata no output", 64'(seen.size()), 64'd0);
    check("nodata in_ready", in_ready, 1'b1);

    // Compressed entries without an anchor are counted and dropped.
    pulse_start();
    put({32'h0, 32'h01020304}, CMP);
    put({32'h0, 32'h01808080}, CMP);
    idle(2);
    check("dropped two", dropped_count, 16'd2);
    check("dropped no output", 64'(seen.size()), 64'd0);
    put({32'd7, 32'd7}, RAW);
    idle(2);
    check("raw after drop count", 64'(seen.size()), 64'd1);
    if (seen.size() == 1) check("raw after drop", seen[0], {32'd7, 32'd7});

    // Backpressure in the middle of unpacking.
    seen.delete();
    put({32'h01010101, 32'h0102FF03}, CMP);
    idle(1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall out_vector", out_vector, {32'd8, 32'd10});
      check("stall out_valid", out_valid, 1'b1);
      check("stall in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(6);
    check("stall count", 64'(seen.size()), 64'd4);
    if (seen.size() == 4) begin
      check("stall 0", seen[0], {32'd8, 32'd10});
      check("stall 1", seen[1], {32'd9, 32'd9});
      check("stall 2", seen[2], {32'd10, 32'd11});
      check("stall 3", seen[3], {32'd11, 32'd12});
    end

    // Modular wrap-around.
    seen.delete();
    put({32'h0, 32'hFFFFFFFF}, RAW);
    put({32'h00808080, 32'h01808080}, CMP);
    idle(3);
    check("wrap count", 64'(seen.size()), 64'd2);
    if (seen.size() == 2) check("wrap value", seen[1], 64'd0);

    // Asynchronous reset in the middle of unpacking.
    put({32'd1, 32'd1}, RAW);
    put({32'h01010101, 32'h01010101}, CMP);
    idle(1);
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", out_valid, 1'b0);
    check("async reset out_vector", out_vector, 64'd0);
    check("async reset dropped", dropped_count, 16'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    seen.delete();
    put({32'h0, 32'h01808080}, CMP);
    idle(2);
    check("post-reset dropped", dropped_count, 16'd1);
    check("post-reset no output", 64'(seen.size()), 64'd0);
    check("model drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
